// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one-cycle sign fix-up, then a one-cycle done pulse.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int          W2        = 2 * XLEN;
    localparam logic [5:0]  LAST_STEP = 6'(ITER - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_r, state_next_s;
    logic [2:0]        funct3_r;
    logic [XLEN-1:0]   opnd_r;
    logic [W2-1:0]     work_r;
    logic              neg_q_r, neg_r_r;
    logic [5:0]        cnt_r;
    logic              busy_r, done_r;
    logic [XLEN-1:0]   result_r;

    logic              accept_s, div_zero_s;
    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_rem_s;
    logic [W2-1:0]     prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_result_s;

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W2-1:0] neg_dword(input logic [W2-1:0] v);
        return ~v + {{(W2-1){1'b0}}, 1'b1};
    endfunction

    // Operand signedness: MULHSU treats only A as signed; funct3[0] marks unsigned divides.
    assign a_signed_s = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_signed_s = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
    assign a_neg_s    = a_signed_s & rs1_data_i[XLEN-1];
    assign b_neg_s    = b_signed_s & rs2_data_i[XLEN-1];
    assign a_mag_s    = a_neg_s ? neg_word(rs1_data_i) : rs1_data_i;
    assign b_mag_s    = b_neg_s ? neg_word(rs2_data_i) : rs2_data_i;
    assign accept_s   = (state_r == ST_IDLE) & start_i & ~flush_i;
    assign div_zero_s = funct3_i[2] & (rs2_data_i == {XLEN{1'b0}});

    // work_r holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum_s   = {1'b0, work_r[W2-1:XLEN]} + (work_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    assign div_shift_s = work_r[W2-1:XLEN-1];
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    assign div_rem_s   = div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];

    assign prod_fix_s = neg_q_r ? neg_dword(work_r) : work_r;
    assign quo_fix_s  = neg_q_r ? neg_word(work_r[XLEN-1:0]) : work_r[XLEN-1:0];
    assign rem_fix_s  = neg_r_r ? neg_word(work_r[W2-1:XLEN]) : work_r[W2-1:XLEN];

    // Result select by operation
    always_comb begin
        fix_result_s = rem_fix_s;
        case (funct3_r)
            3'b000:                 fix_result_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[W2-1:XLEN];
            3'b100, 3'b101:         fix_result_s = quo_fix_s;
            default:                fix_result_s = rem_fix_s;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s)        state_next_s = ST_IDLE;
                else if (div_zero_s)  state_next_s = ST_FIX;
                else if (funct3_i[2]) state_next_s = ST_DIV;
                else                  state_next_s = ST_MUL;
            end
            ST_MUL: begin
                if (flush_i)                 state_next_s = ST_IDLE;
                else if (cnt_r == LAST_STEP) state_next_s = ST_FIX;
                else                         state_next_s = ST_MUL;
            end
            ST_DIV: begin
                if (flush_i)                 state_next_s = ST_IDLE;
                else if (cnt_r == LAST_STEP) state_next_s = ST_FIX;
                else                         state_next_s = ST_DIV;
            end
            ST_FIX: begin
                if (flush_i) state_next_s = ST_IDLE;
                else         state_next_s = ST_DONE;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Datapath, counters and registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            funct3_r <= 3'd0;
            opnd_r   <= {XLEN{1'b0}};
            work_r   <= {W2{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            cnt_r    <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            busy_r <= (state_next_s == ST_MUL) | (state_next_s == ST_DIV) | (state_next_s == ST_FIX);
            done_r <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        funct3_r <= funct3_i;
                        cnt_r    <= 6'd0;
                        if (div_zero_s) begin
                            // Quotient all-ones, remainder is the raw dividend; no sign fix-up.
                            opnd_r  <= {XLEN{1'b0}};
                            work_r  <= {rs1_data_i, {XLEN{1'b1}}};
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                        end else if (funct3_i[2]) begin
                            opnd_r  <= b_mag_s;
                            work_r  <= {{XLEN{1'b0}}, a_mag_s};
                            neg_q_r <= a_neg_s ^ b_neg_s;
                            neg_r_r <= a_neg_s;
                        end else begin
                            opnd_r  <= a_mag_s;
                            work_r  <= {{XLEN{1'b0}}, b_mag_s};
                            neg_q_r <= a_neg_s ^ b_neg_s;
                            neg_r_r <= a_neg_s;
                        end
                    end
                end
                ST_MUL: begin
                    work_r <= {mul_sum_s, work_r[XLEN-1:1]};
                    cnt_r  <= cnt_r + 6'd1;
                end
                ST_DIV: begin
                    work_r <= {div_rem_s, work_r[XLEN-2:0], div_ge_s};
                    cnt_r  <= cnt_r + 6'd1;
                end
                ST_FIX: begin
                    if (!flush_i) result_r <= fix_result_s;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;
    assign stall_o  = busy_r | accept_s;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes the two forwarded operands produced by the EX operand-select muxes and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While it works it raises stall_o so the hazard logic freezes IF/ID/ID-EX. It delivers a one-cycle done_o pulse with result_o for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iteration count; must equal XLEN (one radix-2 step per cycle).

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  launch operation; sampled only in IDLE
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data_i  input  32  forwarded operand A (dividend / multiplicand)
rs2_data_i  input  32  forwarded operand B (divisor / multiplier)
flush_i  input  1  abort current operation (branch/exception flush)
busy_o  output  1  high while an operation is in flight
stall_o  output  1  combinational: busy_o | (start_i & state==IDLE & ~flush_i)
done_o  output  1  one-cycle pulse, result_o valid
result_o  output  32  result; held until next accepted start

Behaviour:
- Reset (async, rst_i=1): state IDLE, busy_o=0, done_o=0, result_o=0, all internal registers 0. Reset mid-operation aborts with no done_o.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: at edge N with start_i=1 and flush_i=0, latch funct3_i, operand magnitudes, and result-sign flags. Go to MUL (funct3[2]=0) or DIV (funct3[2]=1). Clear the 6-bit counter. busy_o=1 from the cycle after edge N.
- Signedness: MUL/MULH: both signed. MULHSU: A signed, B unsigned. MULHU/DIVU/REMU: unsigned. DIV/REM: signed. Negative operands convert to magnitude (two's complement); magnitude of 0x80000000 is 0x80000000 unsigned.
- MUL: 64-bit shift-add, one multiplier bit per cycle, ITER cycles. Then FIX.
- DIV: restoring shift-subtract, one quotient bit per cycle, ITER cycles. Then FIX.
- FIX (1 cycle): negate the 64-bit product if the signs differ. Quotient is negated if the signs differ. Remainder takes the dividend sign. Select low/high 32 bits or quotient/remainder per funct3. Register result_o, go to DONE.
- DONE: done_o=1 for exactly this cycle, busy_o=0; next state IDLE. A start_i seen in DONE is ignored; the pipeline re-presents it in IDLE.
- Latency: start sampled at edge N; done_o high in the cycle after edge N+ITER+1 (34 cycles incl. launch for ITER=32).
- Divide by zero (divisor==0, DIV* or REM*): bypass iteration. DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1_data_i unchanged. Go IDLE→FIX-equivalent; done_o high in the cycle after edge N+1.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): normal path. Quotient 0x80000000, REM 0; no trap.
- flush_i=1 in any non-IDLE state: next edge → IDLE, busy_o=0, no done_o, result_o unchanged. flush_i with start_i in IDLE: start not accepted.
- start_i while busy: ignored; operands are not re-latched. Operand inputs may change freely after launch.
- done_o and busy_o are never high together. stall_o is low in the DONE cycle so the result advances into EX/MEM.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (−3) → done_o after 34 cycles, result_o=0xFFFFFFEB; stall_o high cycles 1–33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, done_o one cycle after launch edge +1. REM 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- flush_i at iteration 10 of DIV → busy_o low next cycle, no done_o, result_o unchanged. A new MUL 3×4 then → 12. start_i toggled mid-op → ignored.
- rst_i asserted asynchronously mid-MUL (between edges) → busy_o, done_o, result_o go 0 immediately. After release, IDLE accepts a new start normally.
